genetic_filter_array: RTL and testbench

//  Multi-channel, clocked successor to the single-channel genetic sensor filter.
//  Per channel: synchronise Start/Sensor, debounce Sensor by programmable on/off

---
 rtl/genetic_filter_array_if.sv | 28 ++
 rtl/genetic_filter_array.sv | 164 ++++++++++++++++
 tb/tb_genetic_filter_array.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/genetic_filter_array_if.sv
// Bundles the per-channel sensor inputs, shared configuration and filtered
// outputs of genetic_filter_array; master drives inputs, slave is the filter.
interface genetic_filter_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int ACW = $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0] start;
  logic [CHANNELS-1:0] sensor;
  logic                mode;
  logic [CNT_W-1:0]    thresh_on;
  logic [CNT_W-1:0]    thresh_off;
  logic [CHANNELS-1:0] actuator;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [ACW-1:0]      active_count;

  modport master (
    output start, sensor, mode, thresh_on, thresh_off,
    input  actuator, rise_pulse, fall_pulse, active_count
  );

  modport slave (
    input  start, sensor, mode, thresh_on, thresh_off,
    output actuator, rise_pulse, fall_pulse, active_count
  );
endinterface

// File: rtl/genetic_filter_array.sv
// Multi-channel sensor debounce filter: synchronised start/sensor, per-channel
// persistence FSM with latched thresholds, follow/latch release modes.
//
// state       | meaning
// S_IDLE      | actuator off, waiting for start_s & sensor_s
// S_RISE_WAIT | counting high persistence towards latched thresh_on
// S_ON        | actuator on, waiting for release condition
// S_FALL_WAIT | actuator on, counting release persistence towards thresh_off
module genetic_filter_array #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  genetic_filter_array_if.slave io
);
  localparam int ACW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RISE_WAIT, S_ON, S_FALL_WAIT} state_t;

  logic [CHANNELS-1:0] r_sync_start  [SYNC_STAGES];
  logic [CHANNELS-1:0] r_sync_sensor [SYNC_STAGES];
  logic [CHANNELS-1:0] w_start_s;
  logic [CHANNELS-1:0] w_sensor_s;
  logic [CHANNELS-1:0] w_act;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [ACW-1:0]      w_pop;
  logic [CNT_W-1:0]    w_on_eff;
  logic [CNT_W-1:0]    w_off_eff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync_start[s]  <= '0;
        r_sync_sensor[s] <= '0;
      end
    end else begin
      r_sync_start[0]  <= io.start;
      r_sync_sensor[0] <= io.sensor;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync_start[s]  <= r_sync_start[s-1];
        r_sync_sensor[s] <= r_sync_sensor[s-1];
      end
    end
  end

  assign w_start_s  = r_sync_start[SYNC_STAGES-1];
  assign w_sensor_s = r_sync_sensor[SYNC_STAGES-1];

  // A programmed threshold of zero behaves as one
  assign w_on_eff  = (io.thresh_on  == '0) ? CNT_W'(1) : io.thresh_on;
  assign w_off_eff = (io.thresh_off == '0) ? CNT_W'(1) : io.thresh_off;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_thr, w_thr_nxt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             r_act, r_rise, r_fall;
    logic             w_rise_nxt, w_fall_nxt;
    logic             w_engage, w_release;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_thr_nxt   = r_thr;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      w_engage    = w_start_s[g] && w_sensor_s[g];
      w_release   = io.mode ? (!w_sensor_s[g] && !w_start_s[g]) : !w_sensor_s[g];
      w_cnt_inc   = (CNT_W+1)'(r_cnt) + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_engage) begin
            w_thr_nxt = w_on_eff;
            if (w_on_eff == CNT_W'(1)) begin
              w_state_nxt = S_ON;
              w_cnt_nxt   = '0;
              w_rise_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RISE_WAIT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        S_RISE_WAIT: begin
          if (!w_engage) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == (CNT_W+1)'(r_thr)) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        S_ON: begin
          if (w_release) begin
            w_thr_nxt = w_off_eff;
            if (w_off_eff == CNT_W'(1)) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_FALL_WAIT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        S_FALL_WAIT: begin
          if (!w_release) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == (CNT_W+1)'(r_thr)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_thr   <= '0;
        r_act   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_thr   <= w_thr_nxt;
        r_act   <= (w_state_nxt == S_ON) || (w_state_nxt == S_FALL_WAIT);
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    assign w_act[g]  = r_act;
    assign w_rise[g] = r_rise;
    assign w_fall[g] = r_fall;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++) w_pop = w_pop + ACW'(w_act[i]);
  end

  assign io.actuator     = w_act;
  assign io.rise_pulse   = w_rise;
  assign io.fall_pulse   = w_fall;
  assign io.active_count = w_pop;
endmodule

// File: tb/tb_genetic_filter_array.sv
// Randomised bench for genetic_filter_array against a persistence-run model
// (actuator flips once the relevant condition has held for thr cycles in a row).
module tb_genetic_filter_array;
  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  genetic_filter_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  genetic_filter_array #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [CH-1:0] h_start  [SYNC];
  logic [CH-1:0] h_sensor [SYNC];
  int            m_run [CH];
  int            m_thr [CH];
  logic [CH-1:0] e_act, e_rise, e_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) begin
      h_start[k]  = '0;
      h_sensor[k] = '0;
    end
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_thr[c] = 0;
    end
    e_act  = '0;
    e_rise = '0;
    e_fall = '0;
  endtask

  task automatic model_edge();
    logic s, st, cond;
    int   t;
    for (int c = 0; c < CH; c++) begin
      s  = h_sensor[SYNC-1][c];
      st = h_start[SYNC-1][c];
      if (e_act[c]) cond = bus.mode ? (!s && !st) : !s;
      else          cond = s && st;
      e_rise[c] = 1'b0;
      e_fall[c] = 1'b0;
      if (cond) begin
        if (m_run[c] == 0) begin
          t = e_act[c] ? int'(bus.thresh_off) : int'(bus.thresh_on);
          m_thr[c] = (t == 0) ? 1 : t;
        end
        m_run[c]++;
        if (m_run[c] >= m_thr[c]) begin
          if (e_act[c]) e_fall[c] = 1'b1;
          else          e_rise[c] = 1'b1;
          e_act[c] = ~e_act[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    for (int k = SYNC - 1; k > 0; k--) begin
      h_start[k]  = h_start[k-1];
      h_sensor[k] = h_sensor[k-1];
    end
    h_start[0]  = bus.start;
    h_sensor[0] = bus.sensor;
  endtask

  task automatic check_all();
    chk("actuator",     32'(bus.actuator),     32'(e_act));
    chk("rise_pulse",   32'(bus.rise_pulse),   32'(e_rise));
    chk("fall_pulse",   32'(bus.fall_pulse),   32'(e_fall));
    chk("active_count", 32'(bus.active_count), 32'($countones(e_act)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int first_rise;

  initial begin
    model_reset();
    bus.start      = '1;
    bus.sensor     = '1;
    bus.mode       = 1'b0;
    bus.thresh_on  = 8'd3;
    bus.thresh_off = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    first_rise = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.actuator[0] && first_rise == 0) first_rise = e;
    end
    chk("reset_release_latency", 32'(first_rise), 32'(SYNC + 3));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 4) == 0) bus.sensor[c] = ~bus.sensor[c];
        if ($urandom_range(0, 7) == 0) bus.start[c]  = ~bus.start[c];
      end
      if ($urandom_range(0, 2) == 0) bus.thresh_on  = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) bus.thresh_off = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 199) == 0) bus.thresh_on = 8'd10;
      step();
      if (cyc % 400 == 399) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
